// File: rtl/neander_pkg.sv
// Shared types for the Neander control unit: opcodes, ALU selects, FSM states and the
// bundle of datapath strobes produced by the output decoder.
package neander_pkg;

    localparam int unsigned OpcodeW = 4;
    localparam int unsigned AluOpW  = 3;

    typedef enum logic [OpcodeW-1:0] {
        OpNop = 4'h0,
        OpSta = 4'h1,
        OpLda = 4'h2,
        OpAdd = 4'h3,
        OpOr  = 4'h4,
        OpAnd = 4'h5,
        OpNot = 4'h6,
        OpJmp = 4'h8,
        OpJn  = 4'h9,
        OpJz  = 4'hA,
        OpHlt = 4'hF
    } opcode_t;

    typedef enum logic [AluOpW-1:0] {
        AluAdd   = 3'd0,
        AluAnd   = 3'd1,
        AluOr    = 3'd2,
        AluNot   = 3'd3,
        AluPassY = 3'd4
    } alu_op_t;

    typedef enum logic [3:0] {
        StFAddr,
        StFRead,
        StFRi,
        StDec,
        StOAddr,
        StORead,
        StJmp,
        StSkip,
        StDAddr,
        StStRdm,
        StStWr,
        StDRead,
        StExec,
        StHalt
    } uc_state_t;

    typedef struct packed {
        logic    load_rem;
        logic    sel_rem;
        logic    load_rdm;
        logic    sel_rdm;
        logic    mem_read;
        logic    mem_write;
        logic    load_ri;
        logic    inc_pc;
        logic    load_pc;
        logic    load_ac;
        logic    load_nz;
        alu_op_t alu_op;
        logic    halted;
    } uc_ctrl_t;

    // Instructions whose operand byte is a branch target rather than a data address.
    function automatic logic is_jump(input logic [OpcodeW-1:0] op);
        return (op == OpJmp) || (op == OpJn) || (op == OpJz);
    endfunction

endpackage

// File: rtl/neander_uc_dec.sv
// Combinational output decoder: maps the current FSM state (and the opcode, in the execute
// state) to the full set of datapath strobes.
module neander_uc_dec
    import neander_pkg::*;
(
    input  uc_state_t            state_i,
    input  logic [OpcodeW-1:0]   opcode_i,
    output uc_ctrl_t             ctrl_o
);

    always_comb begin
        ctrl_o        = '0;
        ctrl_o.alu_op = AluAdd;
        unique case (state_i)
            StFAddr, StOAddr: begin
                ctrl_o.load_rem = 1'b1;
            end
            StFRead, StORead: begin
                ctrl_o.mem_read = 1'b1;
                ctrl_o.load_rdm = 1'b1;
                ctrl_o.inc_pc   = 1'b1;
            end
            StFRi: begin
                ctrl_o.load_ri = 1'b1;
            end
            StJmp: begin
                ctrl_o.load_pc = 1'b1;
            end
            StSkip: begin
                ctrl_o.inc_pc = 1'b1;
            end
            StDAddr: begin
                ctrl_o.sel_rem  = 1'b1;
                ctrl_o.load_rem = 1'b1;
            end
            StStRdm: begin
                ctrl_o.sel_rdm  = 1'b1;
                ctrl_o.load_rdm = 1'b1;
            end
            StStWr: begin
                ctrl_o.mem_write = 1'b1;
            end
            StDRead: begin
                ctrl_o.mem_read = 1'b1;
                ctrl_o.load_rdm = 1'b1;
            end
            StExec: begin
                ctrl_o.load_ac = 1'b1;
                ctrl_o.load_nz = 1'b1;
                case (opcode_i)
                    OpLda:   ctrl_o.alu_op = AluPassY;
                    OpAdd:   ctrl_o.alu_op = AluAdd;
                    OpOr:    ctrl_o.alu_op = AluOr;
                    OpAnd:   ctrl_o.alu_op = AluAnd;
                    OpNot:   ctrl_o.alu_op = AluNot;
                    default: ctrl_o.alu_op = AluAdd;
                endcase
            end
            StHalt: begin
                ctrl_o.halted = 1'b1;
            end
            default: begin
                ctrl_o = '0;
            end
        endcase
    end

endmodule

// File: rtl/neander_uc.sv
// Neander control unit: fetch/decode/execute sequencer driving the REM, RDM, RI, PC, AC, NZ
// and ALU controls. State register and next-state logic live here; outputs come from the decoder.
module neander_uc
    import neander_pkg::*;
#(
    parameter int unsigned OPW  = OpcodeW,
    parameter int unsigned ALUW = AluOpW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [OPW-1:0]  opcode_i,
    input  logic            flag_n_i,
    input  logic            flag_z_i,
    output logic            load_rem_o,
    output logic            sel_rem_o,
    output logic            load_rdm_o,
    output logic            sel_rdm_o,
    output logic            mem_read_o,
    output logic            mem_write_o,
    output logic            load_ri_o,
    output logic            inc_pc_o,
    output logic            load_pc_o,
    output logic            load_ac_o,
    output logic            load_nz_o,
    output logic [ALUW-1:0] alu_op_o,
    output logic            halted_o
);

    uc_state_t state_q, state_d;
    uc_ctrl_t  dec_ctrl;
    uc_ctrl_t  ctrl;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StFAddr;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFAddr: state_d = StFRead;
            StFRead: state_d = StFRi;
            StFRi:   state_d = StDec;
            StDec: begin
                case (opcode_i)
                    OpNot:                        state_d = StExec;
                    OpHlt:                        state_d = StHalt;
                    OpSta, OpLda, OpAdd, OpOr,
                    OpAnd, OpJmp:                 state_d = StOAddr;
                    OpJn:    state_d = flag_n_i ? StOAddr : StSkip;
                    OpJz:    state_d = flag_z_i ? StOAddr : StSkip;
                    // NOP and undefined opcodes fall straight back to fetch.
                    default:                      state_d = StFAddr;
                endcase
            end
            StOAddr: state_d = StORead;
            StORead: state_d = is_jump(opcode_i) ? StJmp : StDAddr;
            StJmp:   state_d = StFAddr;
            StSkip:  state_d = StFAddr;
            StDAddr: state_d = (opcode_i == OpSta) ? StStRdm : StDRead;
            StStRdm: state_d = StStWr;
            StStWr:  state_d = StFAddr;
            StDRead: state_d = StExec;
            StExec:  state_d = StFAddr;
            StHalt:  state_d = StHalt;
            default: state_d = StFAddr;
        endcase
    end

    neander_uc_dec u_dec (
        .state_i  (state_q),
        .opcode_i (opcode_i),
        .ctrl_o   (dec_ctrl)
    );

    // Reset blanks every strobe immediately, even before the first reset edge lands.
    assign ctrl = rst ? '0 : dec_ctrl;

    assign load_rem_o  = ctrl.load_rem;
    assign sel_rem_o   = ctrl.sel_rem;
    assign load_rdm_o  = ctrl.load_rdm;
    assign sel_rdm_o   = ctrl.sel_rdm;
    assign mem_read_o  = ctrl.mem_read;
    assign mem_write_o = ctrl.mem_write;
    assign load_ri_o   = ctrl.load_ri;
    assign inc_pc_o    = ctrl.inc_pc;
    assign load_pc_o   = ctrl.load_pc;
    assign load_ac_o   = ctrl.load_ac;
    assign load_nz_o   = ctrl.load_nz;
    assign alu_op_o    = ALUW'(ctrl.alu_op);
    assign halted_o    = ctrl.halted;

endmodule

// File: tb/tb_neander_uc.sv
// Directed bench for neander_uc: checks the per-cycle strobe vector of each instruction class
// against hand-written sequences, plus reset, halt and reset-during-store behaviour.
module tb_neander_uc;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] opcode;
    logic       flag_n, flag_z;
    logic       load_rem, sel_rem, load_rdm, sel_rdm, mem_read, mem_write;
    logic       load_ri, inc_pc, load_pc, load_ac, load_nz, halted;
    logic [2:0] alu_op;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // Vector bit order: load_rem sel_rem load_rdm sel_rdm mem_read mem_write load_ri
    //                   inc_pc load_pc load_ac load_nz alu_op[2:0] halted
    localparam logic [14:0] V_NONE  = 15'h0000;
    localparam logic [14:0] V_ADDR  = 15'h4000;
    localparam logic [14:0] V_READ  = 15'h1480;
    localparam logic [14:0] V_RI    = 15'h0100;
    localparam logic [14:0] V_DADDR = 15'h6000;
    localparam logic [14:0] V_DREAD = 15'h1400;
    localparam logic [14:0] V_STRDM = 15'h1800;
    localparam logic [14:0] V_STWR  = 15'h0200;
    localparam logic [14:0] V_JMP   = 15'h0040;
    localparam logic [14:0] V_SKIP  = 15'h0080;
    localparam logic [14:0] V_X_LDA = 15'h0038;
    localparam logic [14:0] V_X_ADD = 15'h0030;
    localparam logic [14:0] V_X_OR  = 15'h0034;
    localparam logic [14:0] V_X_AND = 15'h0032;
    localparam logic [14:0] V_X_NOT = 15'h0036;
    localparam logic [14:0] V_HALT  = 15'h0001;

    neander_uc dut (
        .clk         (clk),
        .rst         (rst),
        .opcode_i    (opcode),
        .flag_n_i    (flag_n),
        .flag_z_i    (flag_z),
        .load_rem_o  (load_rem),
        .sel_rem_o   (sel_rem),
        .load_rdm_o  (load_rdm),
        .sel_rdm_o   (sel_rdm),
        .mem_read_o  (mem_read),
        .mem_write_o (mem_write),
        .load_ri_o   (load_ri),
        .inc_pc_o    (inc_pc),
        .load_pc_o   (load_pc),
        .load_ac_o   (load_ac),
        .load_nz_o   (load_nz),
        .alu_op_o    (alu_op),
        .halted_o    (halted)
    );

    always #5 clk = ~clk;

    function automatic logic [14:0] outs();
        return {load_rem, sel_rem, load_rdm, sel_rdm, mem_read, mem_write, load_ri,
                inc_pc, load_pc, load_ac, load_nz, alu_op, halted};
    endfunction

    task automatic check(input string tag, input logic [14:0] got, input logic [14:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %04h expected %04h", tag, got, exp);
        end
    endtask

    // Checks the current cycle mid-period, then advances to the next cycle's negedge.
    task automatic check_cyc(input string tag, input logic [14:0] exp);
        #1;
        check(tag, outs(), exp);
        @(negedge clk);
    endtask

    task automatic run_instr(input string tag, input logic [3:0] op, input logic n,
                             input logic z, input int len, input logic [0:8][14:0] seq);
        opcode = op;
        flag_n = n;
        flag_z = z;
        for (int i = 0; i < len; i++) begin
            check_cyc($sformatf("%s[%0d]", tag, i + 1), seq[i]);
        end
    endtask

    initial begin
        rst    = 1'b1;
        opcode = 4'h0;
        flag_n = 1'b0;
        flag_z = 1'b0;
        @(negedge clk);
        check_cyc("reset0", V_NONE);
        check_cyc("reset1", V_NONE);
        rst = 1'b0;

        run_instr("lda", 4'h2, 1'b0, 1'b0, 9,
            {V_ADDR, V_READ, V_RI, V_NONE, V_ADDR, V_READ, V_DADDR, V_DREAD, V_X_LDA});
        run_instr("add", 4'h3, 1'b0, 1'b0, 9,
            {V_ADDR, V_READ, V_RI, V_NONE, V_ADDR, V_READ, V_DADDR, V_DREAD, V_X_ADD});
        run_instr("or", 4'h4, 1'b1, 1'b1, 9,
            {V_ADDR, V_READ, V_RI, V_NONE, V_ADDR, V_READ, V_DADDR, V_DREAD, V_X_OR});
        run_instr("and", 4'h5, 1'b0, 1'b0, 9,
            {V_ADDR, V_READ, V_RI, V_NONE, V_ADDR, V_READ, V_DADDR, V_DREAD, V_X_AND});
        run_instr("sta", 4'h1, 1'b0, 1'b0, 9,
            {V_ADDR, V_READ, V_RI, V_NONE, V_ADDR, V_READ, V_DADDR, V_STRDM, V_STWR});
        run_instr("not", 4'h6, 1'b0, 1'b0, 5,
            {V_ADDR, V_READ, V_RI, V_NONE, V_X_NOT, V_NONE, V_NONE, V_NONE, V_NONE});
        run_instr("jmp", 4'h8, 1'b0, 1'b0, 7,
            {V_ADDR, V_READ, V_RI, V_NONE, V_ADDR, V_READ, V_JMP, V_NONE, V_NONE});
        run_instr("jn_t", 4'h9, 1'b1, 1'b0, 7,
            {V_ADDR, V_READ, V_RI, V_NONE, V_ADDR, V_READ, V_JMP, V_NONE, V_NONE});
        run_instr("jn_nt", 4'h9, 1'b0, 1'b1, 5,
            {V_ADDR, V_READ, V_RI, V_NONE, V_SKIP, V_NONE, V_NONE, V_NONE, V_NONE});
        run_instr("jz_t", 4'hA, 1'b0, 1'b1, 7,
            {V_ADDR, V_READ, V_RI, V_NONE, V_ADDR, V_READ, V_JMP, V_NONE, V_NONE});
        run_instr("jz_nt", 4'hA, 1'b1, 1'b0, 5,
            {V_ADDR, V_READ, V_RI, V_NONE, V_SKIP, V_NONE, V_NONE, V_NONE, V_NONE});
        run_instr("nop", 4'h0, 1'b0, 1'b0, 4,
            {V_ADDR, V_READ, V_RI, V_NONE, V_NONE, V_NONE, V_NONE, V_NONE, V_NONE});
        run_instr("undef_c", 4'hC, 1'b1, 1'b1, 4,
            {V_ADDR, V_READ, V_RI, V_NONE, V_NONE, V_NONE, V_NONE, V_NONE, V_NONE});
        run_instr("undef_7", 4'h7, 1'b0, 1'b0, 4,
            {V_ADDR, V_READ, V_RI, V_NONE, V_NONE, V_NONE, V_NONE, V_NONE, V_NONE});

        // Halt: fetch, then held; opcode churn while halted must not matter.
        run_instr("hlt", 4'hF, 1'b0, 1'b0, 4,
            {V_ADDR, V_READ, V_RI, V_NONE, V_NONE, V_NONE, V_NONE, V_NONE, V_NONE});
        for (int i = 0; i < 20; i++) begin
            opcode = 4'(i);
            check_cyc($sformatf("halt[%0d]", i + 5), V_HALT);
        end
        rst = 1'b1;
        check_cyc("halt_rst", V_NONE);
        rst = 1'b0;
        check_cyc("halt_release", V_ADDR);

        // Reset inside the store: the write cycle must never appear.
        opcode = 4'h0;
        check_cyc("nop_after_halt[2]", V_READ);
        check_cyc("nop_after_halt[3]", V_RI);
        check_cyc("nop_after_halt[4]", V_NONE);
        run_instr("sta_rst", 4'h1, 1'b0, 1'b0, 7,
            {V_ADDR, V_READ, V_RI, V_NONE, V_ADDR, V_READ, V_DADDR, V_NONE, V_NONE});
        #1;
        check("sta_rst[8]", outs(), V_STRDM);
        rst = 1'b1;
        check_cyc("sta_rst_gate", V_NONE);
        check_cyc("sta_rst_hold", V_NONE);
        rst = 1'b0;
        run_instr("after_rst", 4'h3, 1'b0, 1'b0, 9,
            {V_ADDR, V_READ, V_RI, V_NONE, V_ADDR, V_READ, V_DADDR, V_DREAD, V_X_ADD});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
